// File: rtl/store_commit_queue.sv
// store_commit_queue: circular store buffer between writeback and memory.
// Stores enter speculatively at tail, become committed in order as the ROB
// retires them (cptr), and drain to memory from head. A flush discards the
// speculative region [cptr, tail) and keeps the committed region [head, cptr).
// Optional byte-granular store-to-load forwarding: define STORE_FORWARD_EN.
//
// Handshakes:
//   write : wb_valid && wb_ready accepts a store; wb_ready depends on registers only.
//   drain : mem_write_en && mem_ready transfers entry[head]; while
//           mem_write_en && !mem_ready all mem_* outputs hold stable.
module store_commit_queue #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int QUEUE      = 16,
    parameter int STRB       = DATA_WIDTH / 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wb_valid,
    input  logic [ADDR_WIDTH-1:0]       waddr_wb,
    input  logic [DATA_WIDTH-1:0]       wdata_wb,
    input  logic [STRB-1:0]             wstrb_wb,
    output logic                        wb_ready,
    input  logic                        commit_valid,
    input  logic                        flush,
    output logic                        mem_write_en,
    input  logic                        mem_ready,
    output logic [ADDR_WIDTH-1:0]       mem_waddr,
    output logic [DATA_WIDTH-1:0]       mem_wdata,
    output logic [STRB-1:0]             mem_wstrb,
    input  logic [ADDR_WIDTH-1:0]       load_addr,
    input  logic [STRB-1:0]             load_strb,
    output logic                        fwd_hit,
    output logic                        fwd_partial,
    output logic [DATA_WIDTH-1:0]       fwd_data,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(QUEUE):0]      count
);

    // Pointer width carries one wrap bit above the index bits.
    localparam int IW = $clog2(QUEUE);
    localparam int PW = IW + 1;
    localparam logic [PW-1:0] DEPTH = PW'(QUEUE);

    logic [ADDR_WIDTH-1:0] addr_q [QUEUE];
    logic [DATA_WIDTH-1:0] data_q [QUEUE];
    logic [STRB-1:0]       strb_q [QUEUE];

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] cptr_q, cptr_d;
    logic [PW-1:0] tail_q, tail_d;

    logic wr_en;
    logic commit_en;
    logic drain_en;

    assign count        = tail_q - head_q;
    assign full         = (count == DEPTH);
    assign empty        = (count == '0);
    assign wb_ready     = !full;
    assign mem_write_en = (head_q != cptr_q);
    assign mem_waddr    = addr_q[head_q[IW-1:0]];
    assign mem_wdata    = data_q[head_q[IW-1:0]];
    assign mem_wstrb    = strb_q[head_q[IW-1:0]];

    // A write in a flush cycle is dropped; commit only touches written entries.
    assign wr_en     = wb_valid && wb_ready && !flush;
    assign commit_en = commit_valid && (cptr_q != tail_q);
    assign drain_en  = mem_write_en && mem_ready;

    // Next pointers: commit resolves before flush so a same-cycle commit survives.
    always_comb begin
        head_d = head_q;
        cptr_d = cptr_q;
        tail_d = tail_q;
        if (drain_en)  head_d = head_q + 1'b1;
        if (commit_en) cptr_d = cptr_q + 1'b1;
        if (flush)      tail_d = cptr_d;
        else if (wr_en) tail_d = tail_q + 1'b1;
    end

    // Pointer registers with synchronous reset; reset discards every entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            cptr_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            cptr_q <= cptr_d;
            tail_q <= tail_d;
        end
    end

    // Entry storage; contents are don't-care until covered by the pointers.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            addr_q[tail_q[IW-1:0]] <= waddr_wb;
            data_q[tail_q[IW-1:0]] <= wdata_wb;
            strb_q[tail_q[IW-1:0]] <= wstrb_wb;
        end
    end

`ifdef STORE_FORWARD_EN
    localparam int OFF = $clog2(STRB);

    logic [STRB-1:0]       cov;
    logic [DATA_WIDTH-1:0] fdata;
    logic [IW-1:0]         idx;

    // Walk valid entries oldest to youngest so the youngest match wins per byte.
    always_comb begin
        cov   = '0;
        fdata = '0;
        idx   = '0;
        for (int k = 0; k < QUEUE; k++) begin
            idx = head_q[IW-1:0] + IW'(k);
            if ((PW'(k) < count) &&
                (addr_q[idx][ADDR_WIDTH-1:OFF] == load_addr[ADDR_WIDTH-1:OFF])) begin
                for (int b = 0; b < STRB; b++) begin
                    if (strb_q[idx][b] && load_strb[b]) begin
                        cov[b]           = 1'b1;
                        fdata[b*8 +: 8]  = data_q[idx][b*8 +: 8];
                    end
                end
            end
        end
    end

    assign fwd_hit     = (load_strb != '0) && (cov == load_strb);
    assign fwd_partial = (cov != '0) && (cov != load_strb);
    assign fwd_data    = fdata;
`else
    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{load_addr, load_strb};
    assign fwd_hit     = 1'b0;
    assign fwd_partial = 1'b0;
    assign fwd_data    = '0;
`endif

endmodule

// File: tb/tb_store_commit_queue.sv
// Directed bench for store_commit_queue (default 32/32/16 configuration).
// Inputs change at the falling edge; outputs are checked at the falling edge.
module tb_store_commit_queue;

    logic        clk;
    logic        rst;
    logic        wb_valid;
    logic [31:0] waddr_wb;
    logic [31:0] wdata_wb;
    logic [3:0]  wstrb_wb;
    logic        wb_ready;
    logic        commit_valid;
    logic        flush;
    logic        mem_write_en;
    logic        mem_ready;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] load_addr;
    logic [3:0]  load_strb;
    logic        fwd_hit;
    logic        fwd_partial;
    logic [31:0] fwd_data;
    logic        full;
    logic        empty;
    logic [4:0]  count;

    int checks;
    int errors;

    store_commit_queue dut (
        .clk(clk), .rst(rst),
        .wb_valid(wb_valid), .waddr_wb(waddr_wb), .wdata_wb(wdata_wb),
        .wstrb_wb(wstrb_wb), .wb_ready(wb_ready),
        .commit_valid(commit_valid), .flush(flush),
        .mem_write_en(mem_write_en), .mem_ready(mem_ready),
        .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .load_addr(load_addr), .load_strb(load_strb),
        .fwd_hit(fwd_hit), .fwd_partial(fwd_partial), .fwd_data(fwd_data),
        .full(full), .empty(empty), .count(count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        rst = 1'b1; wb_valid = 1'b0; waddr_wb = '0; wdata_wb = '0; wstrb_wb = '0;
        commit_valid = 1'b0; flush = 1'b0; mem_ready = 1'b0;
        load_addr = '0; load_strb = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // driver tasks
    task automatic write_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        wb_valid = 1'b1; waddr_wb = a; wdata_wb = d; wstrb_wb = s;
        @(negedge clk);
        wb_valid = 1'b0;
    endtask

    task automatic commit_n(input int n);
        commit_valid = 1'b1;
        repeat (n) @(negedge clk);
        commit_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        load_addr = 32'h0000_0100; load_strb = 4'hF;
        #1;
        checks++; if (mem_write_en !== 1'b0) begin errors++; $display("FAIL reset_mem_write_en got %0b exp 0", mem_write_en); end
        checks++; if (wb_ready !== 1'b1) begin errors++; $display("FAIL reset_wb_ready got %0b exp 1", wb_ready); end
        checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL reset_empty_full got %0b/%0b exp 1/0", empty, full); end
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
        checks++; if (fwd_hit !== 1'b0 || fwd_partial !== 1'b0 || fwd_data !== 32'h0) begin
            errors++; $display("FAIL reset_fwd got %0b/%0b/%h exp 0/0/0", fwd_hit, fwd_partial, fwd_data); end
        load_strb = '0;
    endtask

    task automatic test_single();
        mem_ready = 1'b1;
        write_store(32'h100, 32'hDEADBEEF, 4'hF);
        checks++; if (count !== 5'd1 || mem_write_en !== 1'b0) begin
            errors++; $display("FAIL single_written got count %0d en %0b exp 1/0", count, mem_write_en); end
        commit_n(1);
        checks++; if (mem_write_en !== 1'b1 || mem_waddr !== 32'h100 || mem_wdata !== 32'hDEADBEEF || mem_wstrb !== 4'hF) begin
            errors++; $display("FAIL single_drain got %0b %h %h %h exp 1 00000100 deadbeef f", mem_write_en, mem_waddr, mem_wdata, mem_wstrb); end
        @(negedge clk);
        checks++; if (mem_write_en !== 1'b0 || empty !== 1'b1) begin
            errors++; $display("FAIL single_after got en %0b empty %0b exp 0/1", mem_write_en, empty); end
    endtask

    task automatic test_full();
        logic [31:0] exp_q[$];
        logic [31:0] e;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            write_store(32'h1000 + 32'(i * 4), 32'hA000 + 32'(i), 4'hF);
            exp_q.push_back(32'hA000 + 32'(i));
        end
        checks++; if (full !== 1'b1 || wb_ready !== 1'b0 || count !== 5'd16) begin
            errors++; $display("FAIL full_flags got full %0b ready %0b count %0d exp 1/0/16", full, wb_ready, count); end
        write_store(32'h2000, 32'hBAD0BAD0, 4'hF);
        checks++; if (count !== 5'd16 || mem_write_en !== 1'b0) begin
            errors++; $display("FAIL full_ignore got count %0d en %0b exp 16/0", count, mem_write_en); end
        commit_n(16);
        mem_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            e = exp_q.pop_front();
            checks++; if (mem_write_en !== 1'b1 || mem_wdata !== e) begin
                errors++; $display("FAIL full_drain_%0d got en %0b data %h exp 1 %h", i, mem_write_en, mem_wdata, e); end
            @(negedge clk);
        end
        checks++; if (empty !== 1'b1 || mem_write_en !== 1'b0 || wb_ready !== 1'b1) begin
            errors++; $display("FAIL full_wrap_empty got empty %0b en %0b ready %0b exp 1/0/1", empty, mem_write_en, wb_ready); end
        // head and tail wrapped to index 0; the queue must still work normally
        write_store(32'h3000, 32'h0000CAFE, 4'h1);
        commit_n(1);
        checks++; if (mem_write_en !== 1'b1 || mem_wdata !== 32'h0000CAFE || mem_wstrb !== 4'h1) begin
            errors++; $display("FAIL full_post_wrap got en %0b data %h strb %h exp 1 0000cafe 1", mem_write_en, mem_wdata, mem_wstrb); end
        @(negedge clk);
        mem_ready = 1'b0;
    endtask

    task automatic test_flush();
        logic [31:0] exp_q[$];
        logic [31:0] e;
        do_reset();
        for (int i = 0; i < 4; i++) write_store(32'h300 + 32'(i * 4), 32'hF000 + 32'(i), 4'hF);
        commit_n(2);
        flush = 1'b1; wb_valid = 1'b1; waddr_wb = 32'h3F0; wdata_wb = 32'hBAD; wstrb_wb = 4'hF;
        @(negedge clk);
        flush = 1'b0; wb_valid = 1'b0;
        checks++; if (count !== 5'd2 || mem_write_en !== 1'b1) begin
            errors++; $display("FAIL flush_count got %0d en %0b exp 2/1", count, mem_write_en); end
        write_store(32'h350, 32'hF005, 4'hF);
        checks++; if (count !== 5'd3) begin errors++; $display("FAIL flush_refill got %0d exp 3", count); end
        commit_n(1);
        exp_q.push_back(32'hF000); exp_q.push_back(32'hF001); exp_q.push_back(32'hF005);
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            e = exp_q.pop_front();
            checks++; if (mem_write_en !== 1'b1 || mem_wdata !== e) begin
                errors++; $display("FAIL flush_drain_%0d got en %0b data %h exp 1 %h", i, mem_write_en, mem_wdata, e); end
            @(negedge clk);
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL flush_empty got %0b exp 1", empty); end
        mem_ready = 1'b0;
    endtask

    task automatic test_commit_flush();
        do_reset();
        for (int i = 0; i < 3; i++) write_store(32'h400 + 32'(i * 4), 32'hC000 + 32'(i), 4'hF);
        commit_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        commit_valid = 1'b0; flush = 1'b0;
        checks++; if (count !== 5'd1 || mem_write_en !== 1'b1 || mem_wdata !== 32'hC000) begin
            errors++; $display("FAIL cflush_survivor got count %0d en %0b data %h exp 1 1 0000c000", count, mem_write_en, mem_wdata); end
        mem_ready = 1'b1;
        @(negedge clk);
        checks++; if (empty !== 1'b1 || mem_write_en !== 1'b0) begin
            errors++; $display("FAIL cflush_drained got empty %0b en %0b exp 1/0", empty, mem_write_en); end
        mem_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        do_reset();
        write_store(32'h500, 32'h55AA55AA, 4'h3);
        commit_n(1);
        for (int i = 0; i < 5; i++) begin
            checks++; if (mem_write_en !== 1'b1 || mem_waddr !== 32'h500 || mem_wdata !== 32'h55AA55AA || mem_wstrb !== 4'h3) begin
                errors++; $display("FAIL bp_hold_%0d got %0b %h %h %h exp 1 00000500 55aa55aa 3", i, mem_write_en, mem_waddr, mem_wdata, mem_wstrb); end
            @(negedge clk);
        end
        mem_ready = 1'b1;
        @(negedge clk);
        checks++; if (empty !== 1'b1 || mem_write_en !== 1'b0) begin
            errors++; $display("FAIL bp_release got empty %0b en %0b exp 1/0", empty, mem_write_en); end
        mem_ready = 1'b0;
    endtask

    task automatic test_forward();
        logic        eh1, ep1, eh3, ep3;
        logic [31:0] ed1, ed3;
`ifdef STORE_FORWARD_EN
        eh1 = 1'b1; ep1 = 1'b0; ed1 = 32'hAABB3344;
        eh3 = 1'b0; ep3 = 1'b1; ed3 = 32'h12340000;
`else
        eh1 = 1'b0; ep1 = 1'b0; ed1 = 32'h0;
        eh3 = 1'b0; ep3 = 1'b0; ed3 = 32'h0;
`endif
        do_reset();
        write_store(32'h200, 32'h11223344, 4'hF);
        write_store(32'h202, 32'hAABB0000, 4'hC);
        load_addr = 32'h200; load_strb = 4'hF; #1;
        checks++; if (fwd_hit !== eh1 || fwd_partial !== ep1 || fwd_data !== ed1) begin
            errors++; $display("FAIL fwd_merge got %0b/%0b/%h exp %0b/%0b/%h", fwd_hit, fwd_partial, fwd_data, eh1, ep1, ed1); end
        load_addr = 32'h204; #1;
        checks++; if (fwd_hit !== 1'b0 || fwd_partial !== 1'b0 || fwd_data !== 32'h0) begin
            errors++; $display("FAIL fwd_miss got %0b/%0b/%h exp 0/0/0", fwd_hit, fwd_partial, fwd_data); end
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        load_addr = 32'h200; #1;
        checks++; if (fwd_hit !== 1'b0 || fwd_partial !== 1'b0 || fwd_data !== 32'h0) begin
            errors++; $display("FAIL fwd_flushed got %0b/%0b/%h exp 0/0/0", fwd_hit, fwd_partial, fwd_data); end
        @(negedge clk);
        write_store(32'h208, 32'h12345678, 4'hC);
        load_addr = 32'h208; load_strb = 4'hF; #1;
        checks++; if (fwd_hit !== eh3 || fwd_partial !== ep3 || fwd_data !== ed3) begin
            errors++; $display("FAIL fwd_partial got %0b/%0b/%h exp %0b/%0b/%h", fwd_hit, fwd_partial, fwd_data, eh3, ep3, ed3); end
        load_strb = '0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single();
        test_full();
        test_flush();
        test_commit_flush();
        test_backpressure();
        test_forward();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout got running exp finished");
        $fatal(1);
    end

endmodule
